// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the RV32I load/store unit: bus widths, funct3 encodings,
// FSM state type and the funct3/direction legality helper.
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 32
`endif
`ifndef MEM_DATA_WIDTH
`define MEM_DATA_WIDTH 32
`endif
`ifndef MEM_DEPTH
`define MEM_DEPTH 64
`endif
`ifndef F3_LB
`define F3_LB  3'b000
`define F3_LH  3'b001
`define F3_LW  3'b010
`define F3_LBU 3'b100
`define F3_LHU 3'b101
`define F3_SB  3'b000
`define F3_SH  3'b001
`define F3_SW  3'b010
`endif

package load_store_unit_pkg;

    localparam int ADDR_W = `MEM_ADDR_WIDTH;
    localparam int DATA_W = `MEM_DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_t;

    // Unsigned loads have no store counterpart, so 100/101 are only legal for loads.
    function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        case (f3)
            `F3_LB, `F3_LH, `F3_LW: ok = 1'b1;
            `F3_LBU, `F3_LHU:       ok = ~we;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte mask and replication, load selection and
// extension, and the natural-alignment check for half/word accesses.
`ifndef MEM_DATA_WIDTH
`define MEM_DATA_WIDTH 32
`endif
`ifndef F3_LB
`define F3_LB  3'b000
`define F3_LH  3'b001
`define F3_LW  3'b010
`define F3_LBU 3'b100
`define F3_LHU 3'b101
`endif

module lsu_align #(
    parameter int TRANSFER_WIDTH = 4,
    parameter int DATA_WIDTH     = `MEM_DATA_WIDTH
) (
    input  logic [2:0]                funct3,
    input  logic [1:0]                offset,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH-1:0]     rdata,
    output logic [TRANSFER_WIDTH-1:0] transfer,
    output logic [DATA_WIDTH-1:0]     wdata_rep,
    output logic [DATA_WIDTH-1:0]     rdata_ext,
    output logic                      misaligned
);

    logic [7:0]  byte_sel_s;
    logic [15:0] half_sel_s;

    assign byte_sel_s = rdata[{offset, 3'b000} +: 8];
    assign half_sel_s = rdata[{offset[1], 4'b0000} +: 16];

    // Decode access size from funct3 into mask, replicated data and extended result.
    always_comb begin
        transfer   = '0;
        wdata_rep  = '0;
        rdata_ext  = '0;
        misaligned = 1'b0;
        case (funct3)
            `F3_LB: begin
                transfer  = TRANSFER_WIDTH'(1'b1) << offset;
                wdata_rep = {(DATA_WIDTH/8){wdata[7:0]}};
                rdata_ext = {{(DATA_WIDTH-8){byte_sel_s[7]}}, byte_sel_s};
            end
            `F3_LH: begin
                transfer   = TRANSFER_WIDTH'(2'b11) << offset;
                wdata_rep  = {(DATA_WIDTH/16){wdata[15:0]}};
                rdata_ext  = {{(DATA_WIDTH-16){half_sel_s[15]}}, half_sel_s};
                misaligned = offset[0];
            end
            `F3_LW: begin
                transfer   = '1;
                wdata_rep  = wdata;
                rdata_ext  = rdata;
                misaligned = |offset;
            end
            `F3_LBU: begin
                rdata_ext = {{(DATA_WIDTH-8){1'b0}}, byte_sel_s};
            end
            `F3_LHU: begin
                rdata_ext  = {{(DATA_WIDTH-16){1'b0}}, half_sel_s};
                misaligned = offset[0];
            end
            default: begin
                transfer   = '0;
                wdata_rep  = '0;
                rdata_ext  = '0;
                misaligned = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the RV32I execute stage and byte-enabled data memory:
// IDLE -> ACCESS -> RESP handshake FSM with legality checking and registered outputs.
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 32
`endif
`ifndef MEM_DATA_WIDTH
`define MEM_DATA_WIDTH 32
`endif
`ifndef MEM_DEPTH
`define MEM_DEPTH 64
`endif

module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TRANSFER_WIDTH = 4,
    parameter int DEPTH          = `MEM_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic                       req_we_i,
    input  logic [2:0]                 req_funct3_i,
    input  logic [`MEM_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [`MEM_DATA_WIDTH-1:0] req_wdata_i,
    output logic                       resp_valid_o,
    input  logic                       resp_ready_i,
    output logic [`MEM_DATA_WIDTH-1:0] resp_rdata_o,
    output logic                       resp_err_o,
    output logic                       mem_we_o,
    output logic [`MEM_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [`MEM_DATA_WIDTH-1:0] mem_wdata_o,
    output logic [TRANSFER_WIDTH-1:0]  mem_transfer_o,
    input  logic [`MEM_DATA_WIDTH-1:0] mem_rdata_i
);

    lsu_state_t                state_r;
    logic                      we_r;
    logic [2:0]                funct3_r;
    logic [1:0]                offset_r;
    logic [DATA_W-1:0]         wdata_r;

    logic [2:0]                sel_funct3_s;
    logic [1:0]                sel_offset_s;
    logic [DATA_W-1:0]         sel_wdata_s;
    logic [TRANSFER_WIDTH-1:0] transfer_s;
    logic [DATA_W-1:0]         wdata_rep_s;
    logic [DATA_W-1:0]         rdata_ext_s;
    logic                      misaligned_s;
    logic                      out_of_range_s;
    logic                      illegal_s;

    assign req_ready_o = (state_r == ST_IDLE);

    // The aligner sees the live request in IDLE (store setup) and the captured one afterwards (load return).
    always_comb begin
        if (state_r == ST_IDLE) begin
            sel_funct3_s = req_funct3_i;
            sel_offset_s = req_addr_i[1:0];
            sel_wdata_s  = req_wdata_i;
        end else begin
            sel_funct3_s = funct3_r;
            sel_offset_s = offset_r;
            sel_wdata_s  = wdata_r;
        end
    end

    lsu_align #(
        .TRANSFER_WIDTH (TRANSFER_WIDTH),
        .DATA_WIDTH     (DATA_W)
    ) u_align (
        .funct3     (sel_funct3_s),
        .offset     (sel_offset_s),
        .wdata      (sel_wdata_s),
        .rdata      (mem_rdata_i),
        .transfer   (transfer_s),
        .wdata_rep  (wdata_rep_s),
        .rdata_ext  (rdata_ext_s),
        .misaligned (misaligned_s)
    );

    assign out_of_range_s = (req_addr_i[ADDR_W-1:2] >= (ADDR_W-2)'(DEPTH));
    assign illegal_s      = ~funct3_legal(req_we_i, req_funct3_i) | misaligned_s | out_of_range_s;

    // Request/response FSM; memory-side outputs are loaded at acceptance so they are valid throughout ACCESS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            we_r           <= 1'b0;
            funct3_r       <= 3'b000;
            offset_r       <= 2'b00;
            wdata_r        <= '0;
            resp_valid_o   <= 1'b0;
            resp_err_o     <= 1'b0;
            resp_rdata_o   <= '0;
            mem_we_o       <= 1'b0;
            mem_addr_o     <= '0;
            mem_wdata_o    <= '0;
            mem_transfer_o <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        we_r     <= req_we_i;
                        funct3_r <= req_funct3_i;
                        offset_r <= req_addr_i[1:0];
                        wdata_r  <= req_wdata_i;
                        if (illegal_s) begin
                            state_r      <= ST_RESP;
                            resp_valid_o <= 1'b1;
                            resp_err_o   <= 1'b1;
                            resp_rdata_o <= '0;
                        end else begin
                            state_r  <= ST_ACCESS;
                            mem_we_o <= req_we_i;
                            if (req_we_i) begin
                                mem_addr_o     <= {req_addr_i[ADDR_W-1:2], 2'b00};
                                mem_wdata_o    <= wdata_rep_s;
                                mem_transfer_o <= transfer_s;
                            end else begin
                                mem_addr_o     <= {2'b00, req_addr_i[ADDR_W-1:2]};
                                mem_wdata_o    <= '0;
                                mem_transfer_o <= '0;
                            end
                        end
                    end
                end
                ST_ACCESS: begin
                    state_r        <= ST_RESP;
                    mem_we_o       <= 1'b0;
                    mem_transfer_o <= '0;
                    resp_valid_o   <= 1'b1;
                    resp_err_o     <= 1'b0;
                    resp_rdata_o   <= we_r ? '0 : rdata_ext_s;
                end
                ST_RESP: begin
                    if (resp_ready_i) begin
                        state_r      <= ST_IDLE;
                        resp_valid_o <= 1'b0;
                        resp_err_o   <= 1'b0;
                        resp_rdata_o <= '0;
                    end
                end
                default: begin
                    state_r        <= ST_IDLE;
                    resp_valid_o   <= 1'b0;
                    resp_err_o     <= 1'b0;
                    mem_we_o       <= 1'b0;
                    mem_transfer_o <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-array reference model, directed
// corner cases, mid-access reset and randomized traffic with backpressure.
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 32
`endif
`ifndef MEM_DATA_WIDTH
`define MEM_DATA_WIDTH 32
`endif
`ifndef MEM_DEPTH
`define MEM_DEPTH 64
`endif

module tb_load_store_unit;

    localparam int DEPTH = `MEM_DEPTH;

    logic        clk;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_transfer_o;
    logic [31:0] mem_rdata_i;

    int checks = 0;
    int errors = 0;

    logic [7:0]  ref_mem [DEPTH*4];
    logic [31:0] dmem [DEPTH];
    logic        mem_clear;
    int          rd_idx;
    int          wr_idx;

    load_store_unit #(.TRANSFER_WIDTH(4), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_we_i       (req_we_i),
        .req_funct3_i   (req_funct3_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .resp_valid_o   (resp_valid_o),
        .resp_ready_i   (resp_ready_i),
        .resp_rdata_o   (resp_rdata_o),
        .resp_err_o     (resp_err_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_transfer_o (mem_transfer_o),
        .mem_rdata_i    (mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: stores present a byte address, loads a word index.
    assign rd_idx      = int'(mem_addr_o % 32'(DEPTH));
    assign wr_idx      = int'((mem_addr_o >> 2) % 32'(DEPTH));
    assign mem_rdata_i = dmem[rd_idx];

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < DEPTH; i++) dmem[i] <= 32'd0;
        end else if (mem_we_o) begin
            for (int l = 0; l < 4; l++)
                if (mem_transfer_o[l]) dmem[wr_idx][8*l +: 8] <= mem_wdata_o[8*l +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit legal(input bit we, input logic [2:0] f3, input logic [31:0] a);
        int size;
        size = 1 << f3[1:0];
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b0;
        if (we && f3[2]) return 1'b0;
        if (a % size != 0) return 1'b0;
        if (a / 4 >= DEPTH) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a);
        int size;
        logic [31:0] v;
        size = 1 << f3[1:0];
        v = 32'd0;
        for (int i = 0; i < size; i++) v |= 32'(ref_mem[a + i]) << (8 * i);
        if (!f3[2] && size < 4 && v[8*size-1]) v |= ~((32'd1 << (8 * size)) - 32'd1);
        return v;
    endfunction

    task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int stall);
        bit          ok;
        int          size;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [3:0]  exp_mask;
        logic [31:0] exp_wd;
        ok   = legal(we, f3, a);
        size = 1 << f3[1:0];
        chk("req_ready_idle", 32'(req_ready_o), 32'd1);
        req_valid_i  = 1'b1;
        req_we_i     = we;
        req_funct3_i = f3;
        req_addr_i   = a;
        req_wdata_i  = wd;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        if (!ok) begin
            exp_rd  = 32'd0;
            exp_err = 1'b1;
            chk("err_resp_valid_n1", 32'(resp_valid_o), 32'd1);
            chk("err_flag", 32'(resp_err_o), 32'd1);
            chk("err_rdata", resp_rdata_o, 32'd0);
            chk("err_no_we", 32'(mem_we_o), 32'd0);
        end else begin
            exp_err = 1'b0;
            chk("acc_resp_valid_low", 32'(resp_valid_o), 32'd0);
            chk("acc_req_ready_low", 32'(req_ready_o), 32'd0);
            chk("acc_we", 32'(mem_we_o), 32'(we));
            if (we) begin
                exp_mask = 4'b0000;
                for (int i = 0; i < size; i++) exp_mask[int'(a[1:0]) + i] = 1'b1;
                for (int l = 0; l < 4; l++) exp_wd[8*l +: 8] = wd[8*(l % size) +: 8];
                chk("st_addr", mem_addr_o, {a[31:2], 2'b00});
                chk("st_mask", 32'(mem_transfer_o), 32'(exp_mask));
                chk("st_wdata", mem_wdata_o, exp_wd);
                exp_rd = 32'd0;
            end else begin
                chk("ld_addr", mem_addr_o, a >> 2);
                chk("ld_mask", 32'(mem_transfer_o), 32'd0);
                exp_rd = exp_load(f3, a);
            end
            @(posedge clk);
            #1;
            if (we) for (int i = 0; i < size; i++) ref_mem[a + i] = wd[8*i +: 8];
            chk("resp_valid_n2", 32'(resp_valid_o), 32'd1);
            chk("resp_err", 32'(resp_err_o), 32'd0);
            chk("resp_rdata", resp_rdata_o, exp_rd);
            chk("resp_no_we", 32'(mem_we_o), 32'd0);
        end
        for (int s = 0; s < stall; s++) begin
            if (s == 0) begin
                req_valid_i  = 1'b1;
                req_we_i     = 1'b1;
                req_funct3_i = 3'b010;
                req_addr_i   = 32'h0000_0000;
                req_wdata_i  = 32'hFFFF_FFFF;
            end
            @(posedge clk);
            #1;
            req_valid_i = 1'b0;
            chk("bp_valid", 32'(resp_valid_o), 32'd1);
            chk("bp_rdata", resp_rdata_o, exp_rd);
            chk("bp_err", 32'(resp_err_o), 32'(exp_err));
            chk("bp_req_ready", 32'(req_ready_o), 32'd0);
            chk("bp_no_we", 32'(mem_we_o), 32'd0);
        end
        resp_ready_i = 1'b1;
        @(posedge clk);
        #1;
        resp_ready_i = 1'b0;
        chk("done_valid_low", 32'(resp_valid_o), 32'd0);
        chk("done_req_ready", 32'(req_ready_o), 32'd1);
    endtask

    initial begin
        logic [2:0]  f3_pick [8];
        bit          r_we;
        logic [2:0]  r_f3;
        logic [31:0] r_addr;
        int          r_size;
        f3_pick = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2};
        rst          = 1'b1;
        mem_clear    = 1'b1;
        req_valid_i  = 1'b0;
        req_we_i     = 1'b0;
        req_funct3_i = 3'b000;
        req_addr_i   = 32'd0;
        req_wdata_i  = 32'd0;
        resp_ready_i = 1'b0;
        for (int i = 0; i < DEPTH*4; i++) ref_mem[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_resp_valid", 32'(resp_valid_o), 32'd0);
        chk("rst_resp_err", 32'(resp_err_o), 32'd0);
        chk("rst_resp_rdata", resp_rdata_o, 32'd0);
        chk("rst_mem_we", 32'(mem_we_o), 32'd0);
        chk("rst_mem_transfer", 32'(mem_transfer_o), 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'd0);
        chk("rst_mem_wdata", mem_wdata_o, 32'd0);
        rst       = 1'b0;
        mem_clear = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready_o), 32'd1);

        do_req(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 0);
        do_req(1'b1, 3'b000, 32'h13, 32'h0000_00A5, 0);
        do_req(1'b0, 3'b000, 32'h13, 32'h0, 0);
        do_req(1'b0, 3'b100, 32'h13, 32'h0, 0);
        do_req(1'b1, 3'b001, 32'h22, 32'h0000_8001, 0);
        do_req(1'b0, 3'b001, 32'h22, 32'h0, 0);
        do_req(1'b0, 3'b101, 32'h22, 32'h0, 0);
        do_req(1'b1, 3'b010, 32'h04, 32'hCAFE_F00D, 0);
        do_req(1'b1, 3'b010, 32'h00, 32'h1357_9BDF, 0);
        do_req(1'b0, 3'b010, 32'h06, 32'h0, 0);
        do_req(1'b1, 3'b001, 32'h05, 32'hFFFF_FFFF, 0);
        do_req(1'b1, 3'b010, 32'(DEPTH*4), 32'hBAD0_BAD0, 0);
        do_req(1'b0, 3'b011, 32'h08, 32'h0, 0);
        do_req(1'b1, 3'b100, 32'h08, 32'h0000_00FF, 1);
        do_req(1'b0, 3'b010, 32'h04, 32'h0, 5);
        do_req(1'b0, 3'b010, 32'h00, 32'h0, 0);
        do_req(1'b1, 3'b010, 32'(DEPTH*4-4), 32'h8765_4321, 0);
        do_req(1'b0, 3'b001, 32'(DEPTH*4-2), 32'h0, 0);

        // Reset while a word store is in its ACCESS cycle.
        req_valid_i  = 1'b1;
        req_we_i     = 1'b1;
        req_funct3_i = 3'b010;
        req_addr_i   = 32'h30;
        req_wdata_i  = 32'h1234_5678;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        chk("mid_rst_access_we", 32'(mem_we_o), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_we_drop", 32'(mem_we_o), 32'd0);
        chk("mid_rst_transfer", 32'(mem_transfer_o), 32'd0);
        chk("mid_rst_addr", mem_addr_o, 32'd0);
        chk("mid_rst_wdata", mem_wdata_o, 32'd0);
        chk("mid_rst_resp_valid", 32'(resp_valid_o), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_req_ready", 32'(req_ready_o), 32'd1);
        do_req(1'b0, 3'b010, 32'h30, 32'h0, 0);

        for (int n = 0; n < 60; n++) begin
            r_we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) r_f3 = 3'($urandom_range(0, 7));
            else r_f3 = f3_pick[$urandom_range(0, 7)];
            r_size = 1 << r_f3[1:0];
            r_addr = 32'($urandom_range(0, DEPTH*4 - 1));
            if ($urandom_range(0, 3) != 0) r_addr = r_addr & ~(32'(r_size) - 32'd1);
            if ($urandom_range(0, 11) == 0) r_addr = 32'(DEPTH*4) + 32'($urandom_range(0, 7));
            do_req(r_we, r_f3, r_addr, $urandom, int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
